// File: rtl/counterdown16_pkg.sv
// Shared definitions for the counterdown16 loadable down counter.
// Contents:
//   COUNTERDOWN16_WIDTH : default counter / load-value width
//   state_t             : top-level FSM state (IDLE, RUN, DONE), 2-bit encoding
//   cnt_op_t            : operation the FSM requests from the count datapath
package counterdown16_pkg;

  localparam int COUNTERDOWN16_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CNT_HOLD   = 2'd0,
    CNT_DEC    = 2'd1,
    CNT_LOAD   = 2'd2,
    CNT_RELOAD = 2'd3
  } cnt_op_t;

endpackage

// File: rtl/counterdown16_core.sv
// Count datapath for counterdown16: count register, reload register,
// decrementer, load/reload mux and zero/one detection.
// Ports:
//   clock0        in   clock, rising edge
//   reset         in   synchronous active-high reset (clears both registers)
//   op_i          in   cnt_op_t selecting hold / decrement / load / reload
//   load_value_i  in   value written to count and reload on CNT_LOAD
//   count_o       out  current count (registered)
//   reload_o      out  current reload register value
//   count_zero_o  out  count == 0
//   count_one_o   out  count == 1
//   reload_zero_o out  reload register == 0
module counterdown16_core
  import counterdown16_pkg::*;
#(
  parameter int WIDTH = COUNTERDOWN16_WIDTH
) (
  input  logic             clock0,
  input  logic             reset,
  input  cnt_op_t          op_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] reload_o,
  output logic             count_zero_o,
  output logic             count_one_o,
  output logic             reload_zero_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    case (op_i)
      CNT_DEC:    count_d = count_q - WIDTH'(1);
      CNT_LOAD: begin
        count_d  = load_value_i;
        reload_d = load_value_i;
      end
      CNT_RELOAD: count_d = reload_q;
      default:    count_d = count_q;
    endcase
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign count_o       = count_q;
  assign reload_o      = reload_q;
  assign count_zero_o  = (count_q == '0);
  assign count_one_o   = (count_q == WIDTH'(1));
  assign reload_zero_o = (reload_q == '0);

endmodule

// File: rtl/counterdown16_1clk_sync_resetp_reload.sv
// Loadable down counter with start/stop, one-cycle terminal-count pulse and
// optional auto-reload. Command priority per edge: reset > load > stop > start.
// Optional feature macro: COUNTERDOWN16_AUTORELOAD_EN (auto_reload honoured
// only when defined; otherwise the port is present but ignored).
// Ports:
//   clock0      in   sole clock, rising edge
//   reset       in   synchronous active-high reset
//   load        in   capture load_value into count and reload register
//   load_value  in   value captured on load
//   start       in   begin/restart countdown
//   stop        in   abort countdown, hold count
//   auto_reload in   reload instead of finishing at zero
//   count       out  current count
//   busy        out  high while in RUN
//   tc          out  one-cycle terminal-count pulse
//   done        out  high while in DONE
//   dbg_state   out  current FSM state, for observation only
// Handshake: none; every command is a single-cycle level sampled on the edge.
module counterdown16_1clk_sync_resetp_reload
  import counterdown16_pkg::*;
#(
  parameter int WIDTH = COUNTERDOWN16_WIDTH
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output state_t           dbg_state
);

  state_t  state_q, state_d;
  cnt_op_t cnt_op;
  logic    tc_q, tc_d;
  logic    busy_q, busy_d;
  logic    done_q, done_d;
  logic    count_zero, count_one, reload_zero;
  logic    reload_en;
  logic [WIDTH-1:0] reload_val;

`ifdef COUNTERDOWN16_AUTORELOAD_EN
  assign reload_en = auto_reload;
`else
  logic unused_auto_reload;
  assign unused_auto_reload = auto_reload;
  assign reload_en = 1'b0;
`endif

  counterdown16_core #(.WIDTH(WIDTH)) u_core (
    .clock0        (clock0),
    .reset         (reset),
    .op_i          (cnt_op),
    .load_value_i  (load_value),
    .count_o       (count),
    .reload_o      (reload_val),
    .count_zero_o  (count_zero),
    .count_one_o   (count_one),
    .reload_zero_o (reload_zero)
  );

  // Reload value itself is only needed by the core's mux.
  logic unused_reload_val;
  assign unused_reload_val = ^reload_val;

  // State register and registered outputs.
  always_ff @(posedge clock0) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, datapath operation and terminal-count event.
  always_comb begin
    state_d = state_q;
    cnt_op  = CNT_HOLD;
    tc_d    = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      cnt_op  = CNT_LOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (count_one) begin
            tc_d = 1'b1;
            if (reload_en) begin
              cnt_op = CNT_RELOAD;
            end else begin
              cnt_op  = CNT_DEC;
              state_d = ST_DONE;
            end
          end else begin
            cnt_op = CNT_DEC;
          end
        end
        ST_IDLE: begin
          if (start) begin
            if (count_zero) begin
              state_d = ST_DONE;
              tc_d    = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            cnt_op = CNT_RELOAD;
            if (reload_zero) begin
              tc_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decodes of the upcoming state, registered above.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign tc        = tc_q;
  assign dbg_state = state_q;

endmodule
